// File: rtl/row_fetch_arbiter.sv
// rtl/row_fetch_arbiter.sv - fetches one display row from a shared pixel RAM into a shadow buffer while arbitrating host writes
module row_fetch_arbiter #(
  parameter int  COLOR_COUNT     = 3,
  parameter int  COLOR_BITS      = 4,
  parameter int  COL_ADDR_BITS   = 6,
  parameter int  ROW_ADDR_BITS   = 4,
  localparam int PIX_W           = COLOR_COUNT * COLOR_BITS,
  localparam int COLOR_DAT_WIDTH = (2 ** COL_ADDR_BITS) * COLOR_BITS,
  localparam int ROW_DAT_WIDTH   = COLOR_DAT_WIDTH * COLOR_COUNT,
  localparam int MEM_AW          = ROW_ADDR_BITS + COL_ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ROW_ADDR_BITS-1:0] next_row,
  input  logic                     hub_lat,
  output logic [ROW_DAT_WIDTH-1:0] row_in,
  output logic [MEM_AW-1:0]        mem_addr,
  output logic                     mem_we,
  output logic [PIX_W-1:0]         mem_wdata,
  input  logic [PIX_W-1:0]         mem_rdata,
  input  logic                     host_req,
  input  logic [MEM_AW-1:0]        host_addr,
  input  logic [PIX_W-1:0]         host_data,
  output logic                     host_gnt,
  output logic                     fetch_busy,
  output logic                     underrun
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic [ROW_ADDR_BITS-1:0] fetch_row;
  logic                     fetch_row_valid;
  logic [COL_ADDR_BITS-1:0] col;
  logic [ROW_DAT_WIDTH-1:0] shadow;
  logic                     shadow_valid;
  logic                     rd_pend;
  logic [COL_ADDR_BITS-1:0] rd_col;
  logic                     last_fetch;
  logic                     hub_lat_q;

  logic restart;
  logic abort;
  logic host_win;
  logic fetch_issue;
  logic drain_done;
  logic lat_rise;

  always_comb begin
    state_nxt   = state;
    restart     = 1'b0;
    abort       = 1'b0;
    host_win    = 1'b0;
    fetch_issue = 1'b0;
    drain_done  = 1'b0;
    lat_rise    = hub_lat && !hub_lat_q;
    case (state)
      IDLE: begin
        host_win = host_req;
        if (!fetch_row_valid || (next_row != fetch_row)) begin
          restart   = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (next_row != fetch_row) begin
          abort     = 1'b1;
          restart   = 1'b1;
          host_win  = host_req;
        end else if (host_req && last_fetch) begin
          // host only steals a slot right after a fetch read, so fetch keeps at least half
          host_win = 1'b1;
        end else begin
          fetch_issue = 1'b1;
          if (col == {COL_ADDR_BITS{1'b1}}) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        host_win = host_req;
        if (next_row != fetch_row) begin
          abort     = 1'b1;
          restart   = 1'b1;
          state_nxt = FETCH;
        end else begin
          drain_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fetch_busy = (state == FETCH) || (state == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      fetch_row       <= '0;
      fetch_row_valid <= 1'b0;
      col             <= '0;
      shadow          <= '0;
      shadow_valid    <= 1'b0;
      rd_pend         <= 1'b0;
      rd_col          <= '0;
      last_fetch      <= 1'b0;
      hub_lat_q       <= 1'b0;
      row_in          <= '0;
      mem_addr        <= '0;
      mem_we          <= 1'b0;
      mem_wdata       <= '0;
      host_gnt        <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      state      <= state_nxt;
      hub_lat_q  <= hub_lat;
      host_gnt   <= host_win;
      mem_we     <= host_win;
      last_fetch <= fetch_issue;
      rd_pend    <= fetch_issue;
      rd_col     <= col;
      underrun   <= 1'b0;

      if (host_win) begin
        mem_addr  <= host_addr;
        mem_wdata <= host_data;
      end else if (fetch_issue) begin
        mem_addr <= {fetch_row, col};
        col      <= col + COL_ADDR_BITS'(1);
      end

      // an aborted fetch drops its in-flight read so no stale-row pixel lands
      if (rd_pend && !abort) begin
        for (int c = 0; c < COLOR_COUNT; c++) begin
          shadow[c*COLOR_DAT_WIDTH + int'(rd_col)*COLOR_BITS +: COLOR_BITS]
            <= mem_rdata[c*COLOR_BITS +: COLOR_BITS];
        end
      end

      if (drain_done) begin
        shadow_valid    <= 1'b1;
        fetch_row_valid <= 1'b1;
      end

      if (lat_rise) begin
        if (shadow_valid) begin
          row_in       <= shadow;
          shadow_valid <= 1'b0;
        end else begin
          underrun <= 1'b1;
        end
      end

      if (restart) begin
        fetch_row    <= next_row;
        col          <= '0;
        shadow_valid <= 1'b0;
      end
    end
  end

endmodule
